// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Feeds an external combinational 8-bit ALU from a command FIFO. Each command
//   applies acc <= ALU(acc, operand, op). When a command flagged last has been
//   executed, the accumulated value and the command count are offered on the
//   result port. The next sequence then starts again from zero.
//
// Ports
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   cmd_valid/ready    command handshake; cmd_ready is low while the FIFO is full or during reset
//   cmd_op/data/last   op (00 add, 01 sub, 10 xor, 11 shl), operand, end-of-sequence flag
//   alu_a/b/select     ALU operand A (the accumulator), operand B and op select
//   alu_result         combinational ALU output
//   res_valid/ready    result handshake
//   res_data/count     final accumulator and command count (count saturates at 0xFF)
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_last,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_select,
    input  logic [7:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [7:0] res_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e state_q, state_d;

    // FIFO entry layout: {op[1:0], data[7:0], last}
    logic [10:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full;
    logic        push, pop;
    logic [10:0] head;

    logic [7:0] acc_q, acc_d;
    logic [7:0] count_q, count_d;
    logic [7:0] b_q;
    logic [1:0] sel_q;
    logic       last_q;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready  = rst_n && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_data, cmd_last};
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        acc_d   = acc_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                acc_d   = alu_result;
                count_d = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
                if (last_q) begin
                    state_d = StDone;
                end else if (!fifo_empty) begin
                    pop = 1'b1;  // back-to-back issue
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (res_ready) begin
                    acc_d   = 8'h00;
                    count_d = 8'h00;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            acc_q    <= 8'h00;
            count_q  <= 8'h00;
            b_q      <= 8'h00;
            sel_q    <= 2'b00;
            last_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
                sel_q    <= head[10:9];
                b_q      <= head[8:1];
                last_q   <= head[0];
            end
        end
    end

    assign alu_a      = acc_q;
    assign alu_b      = b_q;
    assign alu_select = sel_q;
    assign res_valid  = (state_q == StDone);
    assign res_data   = acc_q;
    assign res_count  = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: directed scenarios plus a randomized phase.
// Expected results come from a sequence-level reference model and are queued
// when a command is accepted. A monitor compares them on each result transfer.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_last;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [1:0] alu_select;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data, res_count;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_last   (cmd_last),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_count  (res_count)
    );

    // Plain modulo-256 arithmetic for the four ALU operations.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
        case (op)
            2'd0:    return 8'(a + b);
            2'd1:    return 8'(a - b);
            2'd2:    return a ^ b;
            default: return 8'(a * 2);
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_select);

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_cyc = -1;
    bit rnd_en = 1'b0;

    logic [15:0] exp_q[$];
    logic [7:0]  m_acc = 8'h00;
    int          m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs change just after posedge, so at negedge they show what
    // the next edge will sample.
    bit         hold = 1'b0;
    bit         prev_valid = 1'b0;
    logic [7:0] held_data, held_count;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_acc      = 8'h00;
            m_cnt      = 0;
            hold       = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                m_acc = alu_fn(m_acc, cmd_data, cmd_op);
                m_cnt++;
                if (cmd_last) begin
                    exp_q.push_back({m_acc, (m_cnt > 255) ? 8'hFF : 8'(m_cnt)});
                    m_acc = 8'h00;
                    m_cnt = 0;
                end
            end
            if (hold) begin
                chk("hold_valid", int'(res_valid), 1);
                chk("hold_data", int'(res_data), int'(held_data));
                chk("hold_count", int'(res_count), int'(held_count));
            end
            if (res_valid && !prev_valid) rise_cyc = cyc;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got data 0x%0h count %0d, none expected",
                             res_data, res_count);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("res_data", int'(res_data), int'(e[15:8]));
                    chk("res_count", int'(res_count), int'(e[7:0]));
                end
            end
            hold       = res_valid && !res_ready;
            held_data  = res_data;
            held_count = res_count;
            prev_valid = res_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_en) res_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] d, input logic l,
                        output int edge_no);
        bit ok;
        ok = 1'b0;
        edge_no = -1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_last  = l;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            step();
            if (ok) break;
        end
        if (ok) edge_no = cyc;
        else begin
            checks++;
            failures++;
            $display("FAIL push_timeout: cmd_ready stayed 0, required 1");
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("drain_pending", exp_q.size(), 0);
        step();
    endtask

    int e0;
    int dummy;
    int idx;
    logic [7:0] bp_data [5];

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 2'd0;
        cmd_data = 8'h5A;
        cmd_last = 1'b1;
        res_ready = 1'b1;

        // Reset with cmd_valid held high.
        repeat (2) begin
            @(negedge clk);
            chk("rst_cmd_ready", int'(cmd_ready), 0);
            chk("rst_alu_a", int'(alu_a), 0);
            chk("rst_alu_b", int'(alu_b), 0);
            chk("rst_alu_select", int'(alu_select), 0);
            chk("rst_res_valid", int'(res_valid), 0);
            chk("rst_res_data", int'(res_data), 0);
            chk("rst_res_count", int'(res_count), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", int'(cmd_ready), 1);
        chk("post_rst_res_valid", int'(res_valid), 0);
        chk("post_rst_alu_a", int'(alu_a), 0);
        step();

        // Basic sequence: ((0+5)+3)^0F = 0x07 over 3 commands.
        rise_cyc = -1;
        push(2'd0, 8'h05, 1'b0, e0);
        push(2'd0, 8'h03, 1'b0, dummy);
        push(2'd2, 8'h0F, 1'b1, dummy);
        drain();
        chk("basic_latency", rise_cyc - e0, 4);

        // Wrap and shift.
        push(2'd0, 8'hF0, 1'b0, dummy);
        push(2'd0, 8'h20, 1'b0, dummy);
        push(2'd1, 8'h20, 1'b1, dummy);
        push(2'd0, 8'h81, 1'b0, dummy);
        push(2'd3, 8'hAA, 1'b1, dummy);
        drain();

        // Single-command latency: result visible after the 2nd edge.
        rise_cyc = -1;
        push(2'd0, 8'h11, 1'b1, e0);
        drain();
        chk("single_latency", rise_cyc - e0, 2);

        // Backpressure: result held while 5 commands are offered for 8 cycles.
        res_ready = 1'b0;
        push(2'd0, 8'h33, 1'b1, dummy);
        for (int i = 0; i < 50; i++) begin
            if (res_valid) break;
            step();
        end
        chk("bp_res_valid", int'(res_valid), 1);
        for (int i = 0; i < 5; i++) bp_data[i] = 8'(i + 1);
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            cmd_valid = (idx < 5);
            cmd_op    = 2'd0;
            cmd_data  = (idx < 5) ? bp_data[idx] : 8'h00;
            cmd_last  = (idx == 4);
            @(negedge clk);
            if (cmd_valid && cmd_ready) idx++;
            step();
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", idx, DEPTH);
        @(negedge clk);
        chk("bp_cmd_ready_full", int'(cmd_ready), 0);
        chk("bp_still_valid", int'(res_valid), 1);
        step();
        res_ready = 1'b1;
        push(2'd0, bp_data[4], 1'b1, dummy);
        drain();

        // Mid-sequence reset discards the partial sequence.
        push(2'd0, 8'h10, 1'b0, dummy);
        push(2'd0, 8'h20, 1'b0, dummy);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        push(2'd0, 8'h01, 1'b1, dummy);
        drain();

        // Count saturation: 300 x add 1 -> 0x2C, count 0xFF.
        for (int i = 0; i < 300; i++) push(2'd0, 8'h01, (i == 299), dummy);
        drain();

        // Randomized traffic with random result backpressure and gaps.
        rnd_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            push(2'($urandom_range(0, 3)), 8'($urandom), (i == 149) || ($urandom_range(0, 3) == 0),
                 dummy);
            repeat ($urandom_range(0, 2)) step();
        end
        rnd_en = 1'b0;
        res_ready = 1'b1;
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven controller for the team's combinational 8-bit ALU (ops: add, sub, xor, shift-left). It accepts a stream of (op, operand) commands through a valid/ready FIFO and drives the ALU's `a`, `b` and `select` inputs from an internal accumulator. It captures each ALU result back into the accumulator and returns the final value of each command sequence over a valid/ready result port. It sits between a command producer and one ALU instance; the ALU itself is external.

## Interface
- `DEPTH`, default 4: command FIFO depth; power of two, at least 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: FIFO not full. Forced to 0 while `rst_n`=0.
- `cmd_op` input 2: 00 add, 01 sub, 10 xor, 11 shift-left.
- `cmd_data` input 8: operand, passed to `alu_b`. Ignored by the ALU for op 11.
- `cmd_last` input 1: this command ends the sequence.
- `alu_a` output 8: equals the accumulator `acc`.
- `alu_b` output 8: latched operand of the current command.
- `alu_select` output 2: latched op of the current command.
- `alu_result` input 8: combinational ALU output.
- `res_valid` output 1: sequence result available.
- `res_ready` input 1: result consumer ready.
- `res_data` output 8: final accumulator value.
- `res_count` output 8: number of commands in the sequence, saturating at 0xFF.

## Operation
- Every sequence starts from `acc`=0x00.
- Each command performs `acc <= ALU(acc, operand, op)`.
- All arithmetic is modulo 256:
  - add and sub wrap.
  - shift-left drops the MSB and shifts in 0.
  - No carry or flag outputs.
- FIFO behaviour:
  - Push on `cmd_valid && cmd_ready`.
  - Each entry holds {op, data, last}.
  - `cmd_ready` = !full; there is no pass-through when full.
  - An entry pushed at edge E can be popped no earlier than edge E+1.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE: if the FIFO is non-empty, pop the head into `alu_select`, `alu_b` and a `last_q` register, then go to ISSUE.
  - ISSUE: the ALU is driven this cycle. At the edge, `acc <= alu_result` and `count <= sat(count+1)`.
    - If `last_q`=1, go to DONE.
    - Else if the FIFO is non-empty, pop the next entry and stay in ISSUE (back-to-back issue).
    - Else go to IDLE.
  - DONE: `res_valid`=1, `res_data`=`acc`, `res_count`=`count`.
    - On `res_ready`: clear `acc` and `count` to 0 and go to IDLE.
    - No pops occur in DONE. The FIFO keeps accepting commands until full.
- `res_data` and `res_count` stay stable while `res_valid`=1 and `res_ready`=0.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Reset, including mid-sequence:
  - Flushes the FIFO and discards any partial sequence.
  - State returns to IDLE.
  - `acc`, `count`, `alu_b` and `alu_select` clear to 0.

## Timing
- Values while `rst_n`=0 and on the first cycle after release:
  - `cmd_ready`=0 during reset, 1 after release.
  - `alu_a`=`alu_b`=0x00, `alu_select`=00.
  - `res_valid`=0, `res_data`=0x00, `res_count`=0x00.
- Single-command latency:
  - The command is accepted at edge E0.
  - It is latched into `alu_select`/`alu_b` at E1.
  - `acc` is updated at E2.
  - `res_valid` rises after E2 if the command has `last`=1.
- Throughput: one command per cycle while the FIFO stays non-empty. N commands accepted at E0..E(N-1) are captured at E2..E(N+1), and `res_valid` rises after E(N+1).
- Result handshake: the transfer completes at the edge where `res_valid && res_ready`. `res_valid` drops the next cycle.
- The earliest next pop is at the edge after the return to IDLE. The DONE→IDLE→ISSUE path therefore adds one idle cycle between sequences.

## Test plan
- Reset check: hold `rst_n`=0 for 2 cycles with `cmd_valid`=1.
  - During reset: `cmd_ready`=0, no push, all outputs 0.
  - After release: `cmd_ready`=1.
- Basic sequence: push add 0x05, add 0x03, xor 0x0F (last), with `res_ready`=1 and a bench ALU model.
  - Required: `res_data`=0x07, `res_count`=3.
  - `res_valid` asserts after the 4th edge following the first accept.
- Wrap and shift: two sequences.
  - add 0xF0, add 0x20, sub 0x20 (last) → 0xF0.
  - add 0x81, shl (last) → 0x02.
- Backpressure: complete a sequence, then hold `res_ready`=0 for 8 cycles while offering 5 commands.
  - Required: `res_valid` stays 1 and `res_data` is stable.
  - Exactly `DEPTH`=4 commands are accepted, and `cmd_ready` drops after the 4th.
  - After `res_ready`=1, the next sequence result is correct with no lost commands.
- Mid-sequence reset: push add 0x10, add 0x20 (not last), pulse `rst_n`=0 for 1 cycle, then push add 0x01 (last).
  - Required: `res_data`=0x01, `res_count`=1.
- Count saturation: push 300 commands of add 0x01, the last flagged.
  - Required: `res_data`=0x2C, `res_count`=0xFF.
